// File: rtl/clk_div_prog_if.sv
// rtl/clk_div_prog_if.sv - control/status bundle for the programmable clock divider
interface clk_div_prog_if #(
   parameter int DIV_W = 8
);
   logic             clk_en;
   logic [DIV_W-1:0] div_val;
   logic             div_load;
   logic             div_busy;
   logic             div_ack;
   logic             div_err;
   logic [DIV_W-1:0] div_active;
   logic             period_stb;
   logic             clk_out;

   modport master (
      output clk_en, div_val, div_load,
      input  div_busy, div_ack, div_err, div_active, period_stb, clk_out
   );

   modport slave (
      input  clk_en, div_val, div_load,
      output div_busy, div_ack, div_err, div_active, period_stb, clk_out
   );
endinterface

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - glitch-free runtime-programmable 50% duty clock divider
module clk_div_prog #(
   parameter int DIV_W     = 8,
   parameter int DIV_RESET = 2
) (
   input  logic          clk_in,
   input  logic          reset_n,
   clk_div_prog_if.slave bus
);
   localparam logic [1:0] ST_STOP = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_PEND = 2'd2;

   localparam logic [DIV_W-1:0] RESET_RATIO = DIV_W'(DIV_RESET);
   localparam logic [DIV_W-1:0] MIN_RATIO   = DIV_W'(2);

   logic [1:0]       state_q, state_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] active_q, active_d;
   logic [DIV_W-1:0] pending_q, pending_d;
   logic             hi_pos_q, hi_pos_d;
   logic             hi_neg_q, hi_neg_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic             stb_q, stb_d;
   logic             boundary;
   logic             load_ok;

   always_comb begin
      state_d   = state_q;
      active_d  = active_q;
      pending_d = pending_q;
      ack_d     = 1'b0;
      err_d     = 1'b0;
      boundary  = (state_q != ST_STOP) && (cnt_q == active_q - 1'b1);
      load_ok   = bus.div_load && (state_q != ST_PEND) && (bus.div_val >= MIN_RATIO);
      if (bus.div_load && !load_ok) begin
         err_d = 1'b1;
      end

      case (state_q)
         ST_STOP: begin
            // No period in flight, so a new ratio can be applied immediately.
            if (load_ok) begin
               active_d  = bus.div_val;
               pending_d = bus.div_val;
               ack_d     = 1'b1;
            end
            if (bus.clk_en) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (boundary && !bus.clk_en) begin
               state_d = ST_STOP;
               if (load_ok) begin
                  active_d  = bus.div_val;
                  pending_d = bus.div_val;
                  ack_d     = 1'b1;
               end
            end else if (load_ok) begin
               pending_d = bus.div_val;
               state_d   = ST_PEND;
            end
         end
         ST_PEND: begin
            if (boundary) begin
               active_d = pending_q;
               ack_d    = 1'b1;
               state_d  = bus.clk_en ? ST_RUN : ST_STOP;
            end
         end
         default: state_d = ST_STOP;
      endcase

      // Output phase is derived from next-state values so clk_out rises
      // directly off the flop at the posedge that opens each period.
      if ((state_d == ST_STOP) || (state_q == ST_STOP) || boundary) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      hi_pos_d = (state_d != ST_STOP) && (cnt_d < (active_d >> 1));
      stb_d    = (state_d != ST_STOP) && (cnt_d == '0);
      hi_neg_d = hi_pos_q;
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_STOP;
         cnt_q     <= '0;
         active_q  <= RESET_RATIO;
         pending_q <= RESET_RATIO;
         hi_pos_q  <= 1'b0;
         ack_q     <= 1'b0;
         err_q     <= 1'b0;
         stb_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         hi_pos_q  <= hi_pos_d;
         ack_q     <= ack_d;
         err_q     <= err_d;
         stb_q     <= stb_d;
      end
   end

   // Half-cycle extension of the high phase for odd ratios.
   always_ff @(negedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         hi_neg_q <= 1'b0;
      end else begin
         hi_neg_q <= hi_neg_d;
      end
   end

   assign bus.div_busy   = (state_q == ST_PEND);
   assign bus.div_ack    = ack_q;
   assign bus.div_err    = err_q;
   assign bus.div_active = active_q;
   assign bus.period_stb = stb_q;
   assign bus.clk_out    = hi_pos_q | (active_q[0] & hi_neg_q);
endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - directed self-checking bench for clk_div_prog
module tb_clk_div_prog;
   localparam int DIV_W = 8;

   logic clk_in;
   logic reset_n;
   int   checks;
   int   errors;

   clk_div_prog_if #(.DIV_W(DIV_W)) bus ();

   clk_div_prog #(.DIV_W(DIV_W), .DIV_RESET(2)) u_dut (
      .clk_in  (clk_in),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic half_neg();
      @(negedge clk_in);
      #1;
   endtask

   task automatic wait_ack(input int max_cycles);
      int n;
      n = 0;
      while (bus.div_ack !== 1'b1 && n < max_cycles) begin
         tick();
         n++;
      end
      chk("ack_seen", 32'(bus.div_ack), 32'(1));
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      reset_n      = 1'b0;
      bus.clk_en   = 1'b0;
      bus.div_load = 1'b0;
      bus.div_val  = '0;
      repeat (3) tick();

      chk("rst_clk_out", 32'(bus.clk_out), 32'(0));
      chk("rst_active", 32'(bus.div_active), 32'(2));
      chk("rst_busy", 32'(bus.div_busy), 32'(0));
      chk("rst_ack", 32'(bus.div_ack), 32'(0));
      chk("rst_err", 32'(bus.div_err), 32'(0));
      chk("rst_stb", 32'(bus.period_stb), 32'(0));

      reset_n = 1'b1;
      tick();
      chk("stop_clk_out", 32'(bus.clk_out), 32'(0));

      // Divide by 2 straight out of reset
      bus.clk_en = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("div2_clk_out", 32'(bus.clk_out), 32'(i % 2 == 0));
         chk("div2_stb", 32'(bus.period_stb), 32'(i % 2 == 0));
         if (i < 5) tick();
      end

      // Load 7 at the last cycle of a 2-period
      bus.div_load = 1'b1;
      bus.div_val  = 8'd7;
      tick();
      bus.div_load = 1'b0;
      chk("l7_busy", 32'(bus.div_busy), 32'(1));
      chk("l7_active_old", 32'(bus.div_active), 32'(2));
      chk("l7_clk_hi", 32'(bus.clk_out), 32'(1));
      tick();
      chk("l7_clk_lo", 32'(bus.clk_out), 32'(0));
      chk("l7_ack_early", 32'(bus.div_ack), 32'(0));
      tick();
      chk("l7_ack", 32'(bus.div_ack), 32'(1));
      chk("l7_busy_clr", 32'(bus.div_busy), 32'(0));
      chk("l7_active", 32'(bus.div_active), 32'(7));
      chk("l7_stb", 32'(bus.period_stb), 32'(1));
      for (int h = 0; h < 28; h++) begin
         chk("div7_half", 32'(bus.clk_out), 32'((h % 14) < 7));
         if (h % 2 == 0) half_neg();
         else tick();
      end

      // Load 4 mid-period of a 7-period; the 7-period must complete first
      chk("div7_stb", 32'(bus.period_stb), 32'(1));
      tick();
      tick();
      bus.div_load = 1'b1;
      bus.div_val  = 8'd4;
      tick();
      bus.div_load = 1'b0;
      chk("l4_busy", 32'(bus.div_busy), 32'(1));
      repeat (3) tick();
      chk("l4_active_hold", 32'(bus.div_active), 32'(7));
      chk("l4_clk_lo", 32'(bus.clk_out), 32'(0));
      tick();
      chk("l4_ack", 32'(bus.div_ack), 32'(1));
      chk("l4_active", 32'(bus.div_active), 32'(4));
      for (int h = 0; h < 16; h++) begin
         chk("div4_half", 32'(bus.clk_out), 32'((h % 8) < 4));
         if (h % 2 == 0) half_neg();
         else tick();
      end

      // Rejected loads: ratio below 2, then a second load while busy
      bus.div_load = 1'b1;
      bus.div_val  = 8'd1;
      tick();
      chk("bad_err", 32'(bus.div_err), 32'(1));
      chk("bad_busy", 32'(bus.div_busy), 32'(0));
      chk("bad_active", 32'(bus.div_active), 32'(4));
      bus.div_val = 8'd5;
      tick();
      chk("l5_err", 32'(bus.div_err), 32'(0));
      chk("l5_busy", 32'(bus.div_busy), 32'(1));
      bus.div_val = 8'd9;
      tick();
      bus.div_load = 1'b0;
      chk("dbl_err", 32'(bus.div_err), 32'(1));
      chk("dbl_busy", 32'(bus.div_busy), 32'(1));
      tick();
      chk("dbl_err_pulse", 32'(bus.div_err), 32'(0));
      wait_ack(20);
      chk("l5_active", 32'(bus.div_active), 32'(5));

      // Switch to 6, then drop clk_en at cnt=1
      bus.div_load = 1'b1;
      bus.div_val  = 8'd6;
      tick();
      bus.div_load = 1'b0;
      wait_ack(20);
      chk("l6_active", 32'(bus.div_active), 32'(6));
      chk("l6_clk_hi", 32'(bus.clk_out), 32'(1));
      tick();
      bus.clk_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("stop6_clk_out", 32'(bus.clk_out), 32'(i == 0));
      end
      chk("stop6_stb", 32'(bus.period_stb), 32'(0));

      // Load while stopped applies at once without going busy
      bus.div_load = 1'b1;
      bus.div_val  = 8'd6;
      tick();
      bus.div_load = 1'b0;
      chk("stopld_ack", 32'(bus.div_ack), 32'(1));
      chk("stopld_busy", 32'(bus.div_busy), 32'(0));
      chk("stopld_active", 32'(bus.div_active), 32'(6));

      // Restart with a full high phase
      bus.clk_en = 1'b1;
      tick();
      chk("restart_stb", 32'(bus.period_stb), 32'(1));
      for (int i = 0; i < 4; i++) begin
         chk("restart_clk_out", 32'(bus.clk_out), 32'(i < 3));
         tick();
      end
      tick();
      tick();
      chk("pre_rst_clk_hi", 32'(bus.clk_out), 32'(1));

      // Asynchronous reset in the middle of the high phase
      #2;
      reset_n    = 1'b0;
      bus.clk_en = 1'b0;
      #1;
      chk("async_clk_out", 32'(bus.clk_out), 32'(0));
      chk("async_active", 32'(bus.div_active), 32'(2));
      chk("async_busy", 32'(bus.div_busy), 32'(0));
      #3;
      reset_n = 1'b1;
      tick();
      tick();
      chk("post_rst_clk_out", 32'(bus.clk_out), 32'(0));
      chk("post_rst_stb", 32'(bus.period_stb), 32'(0));
      bus.clk_en = 1'b1;
      tick();
      chk("post_rst_run_hi", 32'(bus.clk_out), 32'(1));
      chk("post_rst_run_stb", 32'(bus.period_stb), 32'(1));
      tick();
      chk("post_rst_run_lo", 32'(bus.clk_out), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
